// File: rtl/lut_func_eval.sv
// lut_func_eval: N_FUNC reloadable truth tables over N_IN inputs.
// Evaluates single vectors with one cycle of latency, or sweeps every
// minterm once and reports the ON-set size of each function.
//
// Handshake rules:
//   cfg_valid/cfg_ready: a table load happens on an edge where both are high.
//     cfg_ready is high only while idle, so loads offered mid-sweep are
//     dropped rather than stalled.
//   in_valid has no ready. A vector offered outside IDLE is dropped.
//   out_valid is a one-cycle qualifier for out_idx/out_f with no backpressure.
module lut_func_eval #(
    parameter int N_IN   = 4,
    parameter int N_FUNC = 3,
    parameter logic [N_FUNC*(2**N_IN)-1:0] INIT = 48'hB0A0_CAC2_3232
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [((N_FUNC > 1) ? $clog2(N_FUNC) : 1)-1:0] cfg_sel,
    input  logic [(2**N_IN)-1:0]       cfg_table,
    input  logic                       in_valid,
    input  logic [N_IN-1:0]            in_vec,
    output logic                       out_valid,
    output logic [N_IN-1:0]            out_idx,
    output logic [N_FUNC-1:0]          out_f,
    input  logic                       sweep_start,
    output logic                       sweep_busy,
    output logic                       sweep_done,
    output logic [N_FUNC*(N_IN+1)-1:0] sweep_cnt,
    output logic [1:0]                 dbg_state
);

    localparam int TW = 2**N_IN;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [TW-1:0]   tbl [N_FUNC];
    logic [N_IN:0]   cnt [N_FUNC];
    logic [N_IN-1:0] idx;
    logic            sel_ok;

    // Out-of-range selects are ignored so a bad index never corrupts a table.
    assign sel_ok = (int'(cfg_sel) < N_FUNC);

    // Status flags follow the FSM state directly.
    assign cfg_ready  = (state == ST_IDLE);
    assign sweep_busy = (state != ST_IDLE);
    assign dbg_state  = state;

    // Pack per-function ON-set counters into the flat output bus.
    for (genvar k = 0; k < N_FUNC; k++) begin : g_cnt
        assign sweep_cnt[k*(N_IN+1) +: (N_IN+1)] = cnt[k];
    end

    // FSM, table storage, evaluation and sweep counting in one clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_f      <= '0;
            sweep_done <= 1'b0;
            for (int k = 0; k < N_FUNC; k++) begin
                tbl[k] <= INIT[k*TW +: TW];
                cnt[k] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    sweep_done <= 1'b0;
                    // Evaluation reads the table as it stood before this edge,
                    // so a same-edge load only affects later vectors.
                    if (in_valid) begin
                        out_valid <= 1'b1;
                        out_idx   <= in_vec;
                        for (int k = 0; k < N_FUNC; k++) begin
                            out_f[k] <= tbl[k][in_vec];
                        end
                    end else begin
                        out_valid <= 1'b0;
                    end
                    if (cfg_valid && sel_ok) begin
                        tbl[cfg_sel] <= cfg_table;
                    end
                    // The first minterm is read on the next edge, so a load
                    // accepted together with the start is already visible.
                    if (sweep_start) begin
                        state <= ST_SWEEP;
                        idx   <= '0;
                        for (int k = 0; k < N_FUNC; k++) begin
                            cnt[k] <= '0;
                        end
                    end
                end
                ST_SWEEP: begin
                    out_valid <= 1'b1;
                    out_idx   <= idx;
                    for (int k = 0; k < N_FUNC; k++) begin
                        out_f[k] <= tbl[k][idx];
                        cnt[k]   <= cnt[k] + (N_IN+1)'(tbl[k][idx]);
                    end
                    idx <= idx + 1'b1;
                    if (idx == {N_IN{1'b1}}) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    out_valid  <= 1'b0;
                    sweep_done <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_func_eval.sv
// tb_lut_func_eval: directed and randomized checks of lut_func_eval
// against a truth-table model kept as plain 16-bit words.
module tb_lut_func_eval;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_sel = '0;
    logic [15:0] cfg_table = '0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_vec = '0;
    logic        out_valid;
    logic [3:0]  out_idx;
    logic [2:0]  out_f;
    logic        sweep_start = 1'b0;
    logic        sweep_busy;
    logic        sweep_done;
    logic [14:0] sweep_cnt;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] model [3];

    lut_func_eval dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_sel(cfg_sel), .cfg_table(cfg_table),
        .in_valid(in_valid), .in_vec(in_vec),
        .out_valid(out_valid), .out_idx(out_idx), .out_f(out_f),
        .sweep_start(sweep_start), .sweep_busy(sweep_busy),
        .sweep_done(sweep_done), .sweep_cnt(sweep_cnt),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model[0] = 16'h3232;
        model[1] = 16'hCAC2;
        model[2] = 16'hB0A0;
    endtask

    // Value of every function at minterm m.
    function automatic logic [2:0] mf(input int m);
        logic [2:0] r;
        for (int k = 0; k < 3; k++) r[k] = 1'((model[k] >> m) & 16'd1);
        return r;
    endfunction

    // ON-set sizes packed as func2,func1,func0 in 5-bit fields.
    function automatic logic [14:0] exp_cnt();
        logic [14:0] r = '0;
        for (int k = 0; k < 3; k++) begin
            int c = 0;
            for (int m = 0; m < 16; m++) c += (model[k] >> m) & 1;
            r[k*5 +: 5] = 5'(c);
        end
        return r;
    endfunction

    task automatic eval(input logic [3:0] v);
        logic [2:0] e;
        e = mf(int'(v));
        in_valid = 1'b1;
        in_vec = v;
        tick();
        in_valid = 1'b0;
        check("eval_valid", 32'(out_valid), 32'd1);
        check("eval_idx", 32'(out_idx), 32'(v));
        check("eval_f", 32'(out_f), 32'(e));
    endtask

    task automatic load(input logic [1:0] sel, input logic [15:0] t);
        check("load_ready", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1;
        cfg_sel = sel;
        cfg_table = t;
        tick();
        cfg_valid = 1'b0;
        if (sel < 2'd3) model[sel] = t;
    endtask

    // Runs a full sweep; noise_at >= 0 pokes every input during that sweep cycle.
    task automatic run_sweep(input int noise_at, input bit with_load,
                             input logic [1:0] sel, input logic [15:0] t);
        sweep_start = 1'b1;
        if (with_load) begin
            cfg_valid = 1'b1;
            cfg_sel = sel;
            cfg_table = t;
        end
        tick();
        sweep_start = 1'b0;
        cfg_valid = 1'b0;
        if (with_load && sel < 2'd3) model[sel] = t;
        for (int i = 0; i < 16; i++) begin
            if (i == noise_at) begin
                check("sweep_cfg_ready", 32'(cfg_ready), 32'd0);
                cfg_valid = 1'b1;
                cfg_sel = 2'($urandom_range(0, 2));
                cfg_table = 16'($urandom);
                in_valid = 1'b1;
                in_vec = 4'($urandom);
                sweep_start = 1'b1;
            end
            tick();
            cfg_valid = 1'b0;
            in_valid = 1'b0;
            sweep_start = 1'b0;
            check("sweep_valid", 32'(out_valid), 32'd1);
            check("sweep_idx", 32'(out_idx), 32'(i));
            check("sweep_f", 32'(out_f), 32'(mf(i)));
            check("sweep_busy", 32'(sweep_busy), 32'd1);
            check("sweep_early_done", 32'(sweep_done), 32'd0);
        end
        tick();
        check("done_pulse", 32'(sweep_done), 32'd1);
        check("done_valid", 32'(out_valid), 32'd0);
        check("done_cnt", 32'(sweep_cnt), 32'(exp_cnt()));
        tick();
        check("done_clear", 32'(sweep_done), 32'd0);
        check("cnt_hold", 32'(sweep_cnt), 32'(exp_cnt()));
        check("idle_ready", 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        logic [2:0]  e;
        logic [14:0] c;
        model_reset();

        // Reset state
        rst = 1'b1;
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_f", 32'(out_f), 32'd0);
        check("rst_done", 32'(sweep_done), 32'd0);
        check("rst_cnt", 32'(sweep_cnt), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_busy", 32'(sweep_busy), 32'd0);
        rst = 1'b0;
        tick();

        // Default tables, directed vectors
        eval(4'd5);
        check("dir_f5", 32'(out_f), 32'b101);
        eval(4'd6);
        check("dir_f6", 32'(out_f), 32'b010);
        eval(4'd0);
        check("dir_f0", 32'(out_f), 32'b000);
        tick();
        check("hold_valid", 32'(out_valid), 32'd0);
        check("hold_idx", 32'(out_idx), 32'd0);

        // Sweep of the reset tables
        run_sweep(-1, 1'b0, 2'd0, 16'h0);
        c = {5'd5, 5'd7, 5'd6};
        check("dir_cnt_init", 32'(sweep_cnt), 32'(c));

        // Full and empty function counts
        load(2'd0, 16'hFFFF);
        run_sweep(-1, 1'b0, 2'd0, 16'h0);
        check("dir_cnt_full", 32'(sweep_cnt[4:0]), 32'd16);
        load(2'd0, 16'h0000);
        run_sweep(-1, 1'b0, 2'd0, 16'h0);
        check("dir_cnt_empty", 32'(sweep_cnt[4:0]), 32'd0);

        // Out-of-range select leaves tables alone
        load(2'd3, 16'h1234);
        run_sweep(-1, 1'b0, 2'd0, 16'h0);

        // Load and evaluate on the same edge: old table used
        e = mf(5);
        cfg_valid = 1'b1;
        cfg_sel = 2'd2;
        cfg_table = 16'h8000;
        in_valid = 1'b1;
        in_vec = 4'd5;
        tick();
        cfg_valid = 1'b0;
        in_valid = 1'b0;
        check("same_edge_f", 32'(out_f), 32'(e));
        check("same_edge_f2", 32'(out_f[2]), 32'd1);
        model[2] = 16'h8000;
        eval(4'd5);
        check("after_load_f2", 32'(out_f[2]), 32'd0);

        // Sweep with ignored traffic mid-way, and a load on the start edge
        run_sweep(6, 1'b0, 2'd0, 16'h0);
        run_sweep(-1, 1'b1, 2'd1, 16'hA5F0);

        // Reset mid-sweep at idx 7
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("pre_rst_idx", 32'(out_idx), 32'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_cnt", 32'(sweep_cnt), 32'd0);
        check("mid_rst_busy", 32'(sweep_busy), 32'd0);
        check("mid_rst_ready", 32'(cfg_ready), 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("mid_rst_no_done", 32'(sweep_done), 32'd0);
        end
        run_sweep(-1, 1'b0, 2'd0, 16'h0);

        // Randomized loads, evaluations and sweeps
        for (int r = 0; r < 8; r++) begin
            load(2'($urandom_range(0, 3)), 16'($urandom));
            for (int j = 0; j < 8; j++) begin
                eval(4'($urandom));
                if ($urandom_range(0, 1) == 1) tick();
            end
            run_sweep($urandom_range(0, 1) == 1 ? int'($urandom_range(0, 15)) : -1,
                      1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
